// File: rtl/freq_text_render.sv
// Frequency readout overlay: converts a captured Hz value to BCD once per frame and
// renders "FREQ:nnnnnnnn HZ" as 5x7 font dots with a fixed two-cycle pixel latency.
module freq_text_render #(
  parameter int unsigned TEXT_X0    = 16,
  parameter int unsigned TEXT_Y0    = 16,
  parameter int unsigned SCALE_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [26:0] freq_hz,
  input  logic        frame_start,
  input  logic [10:0] pix_x,
  input  logic [9:0]  pix_y,
  output logic [7:0]  font_ascii,
  output logic [2:0]  font_row,
  input  logic [4:0]  font_bits,
  output logic        text_on,
  output logic        busy
);

  localparam int unsigned FREQ_W   = 27;
  localparam int unsigned BCD_W    = 32;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned ITERS    = 27;
  localparam int unsigned MAX_FREQ = 99_999_999;
  localparam int unsigned BOX_W    = 128 << SCALE_LOG2;
  localparam int unsigned BOX_H    = 7 << SCALE_LOG2;
  localparam logic [7:0]  CH_SPACE = 8'h20;
  localparam logic [7:0]  CH_ZERO  = 8'h30;

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_start;
  logic               w_iter;
  logic               w_last;
  logic [FREQ_W-1:0]  r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [BCD_W-1:0]   r_disp;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_shifted;
  logic [FREQ_W-1:0]  w_clamped;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (frame_start) w_next = S_CONV;
      S_CONV: if (r_cnt == CNT_W'(ITERS - 1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_start = 1'b0;
    w_iter  = 1'b0;
    w_last  = 1'b0;
    case (r_state)
      S_IDLE: w_start = frame_start;
      S_CONV: begin
        w_iter = 1'b1;
        w_last = (r_cnt == CNT_W'(ITERS - 1));
      end
      default: ;
    endcase
  end

  // Double-dabble step: add 3 to nibbles >= 5, then shift in the next binary MSB
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 8; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_shifted = {w_adj[BCD_W-2:0], r_bin[FREQ_W-1]};
  end

  assign w_clamped = (freq_hz > FREQ_W'(MAX_FREQ)) ? FREQ_W'(MAX_FREQ) : freq_hz;

  // The last iteration's result goes straight to the display so all digits change together
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_disp <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_next == S_CONV);
      if (w_start) begin
        r_bin <= w_clamped;
        r_bcd <= '0;
        r_cnt <= '0;
      end else if (w_iter) begin
        r_bin <= {r_bin[FREQ_W-2:0], 1'b0};
        r_bcd <= w_shifted;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_last) r_disp <= w_shifted;
    end
  end

  assign busy = r_busy;

  logic        w_in_box;
  logic [10:0] w_rel_x;
  logic [9:0]  w_rel_y;
  logic [3:0]  w_char;
  logic [2:0]  w_col;
  logic [2:0]  w_row;
  logic [2:0]  w_dig_idx;
  logic [3:0]  w_nib;
  logic [7:0]  w_blank;
  logic [7:0]  w_ascii;
  logic [7:0]  r_font_ascii;
  logic [2:0]  r_font_row;
  logic [2:0]  r_col;
  logic        r_valid;
  logic        r_text_on;
  logic [4:0]  w_dots;

  assign w_in_box = (32'(pix_x) >= TEXT_X0) && (32'(pix_x) < TEXT_X0 + BOX_W) &&
                    (32'(pix_y) >= TEXT_Y0) && (32'(pix_y) < TEXT_Y0 + BOX_H);
  assign w_rel_x   = pix_x - 11'(TEXT_X0);
  assign w_rel_y   = pix_y - 10'(TEXT_Y0);
  assign w_char    = 4'(w_rel_x >> (SCALE_LOG2 + 3));
  assign w_col     = 3'(w_rel_x >> SCALE_LOG2);
  assign w_row     = 3'(w_rel_y >> SCALE_LOG2);
  assign w_dig_idx = 3'(4'd12 - w_char);
  assign w_nib     = r_disp[{w_dig_idx, 2'b00} +: 4];

  // A digit is blanked while it and every more significant digit are zero
  always_comb begin
    w_blank    = '0;
    w_blank[7] = (r_disp[31:28] == 4'd0);
    for (int i = 6; i >= 1; i--) begin
      w_blank[i] = w_blank[i+1] && (r_disp[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    w_ascii = CH_SPACE;
    if (w_in_box) begin
      case (w_char)
        4'd0:    w_ascii = 8'h46;
        4'd1:    w_ascii = 8'h52;
        4'd2:    w_ascii = 8'h45;
        4'd3:    w_ascii = 8'h51;
        4'd4:    w_ascii = 8'h3A;
        4'd13:   w_ascii = CH_SPACE;
        4'd14:   w_ascii = 8'h48;
        4'd15:   w_ascii = 8'h5A;
        default: w_ascii = w_blank[w_dig_idx] ? CH_SPACE : (CH_ZERO + {4'h0, w_nib});
      endcase
    end
  end

  // Columns 5..7 shift the glyph fully out, leaving them dark
  assign w_dots = 5'(font_bits << r_col);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_font_ascii <= CH_SPACE;
      r_font_row   <= '0;
      r_col        <= '0;
      r_valid      <= 1'b0;
      r_text_on    <= 1'b0;
    end else begin
      r_font_ascii <= w_ascii;
      r_font_row   <= w_in_box ? w_row : 3'd0;
      r_col        <= w_col;
      r_valid      <= w_in_box;
      r_text_on    <= r_valid && w_dots[4];
    end
  end

  assign font_ascii = r_font_ascii;
  assign font_row   = r_font_row;
  assign text_on    = r_text_on;

endmodule

// File: tb/tb_freq_text_render.sv
// Self-checking bench for freq_text_render: conversion timing, displayed string and
// pixel pipeline checked against an arithmetic reference model with random stimulus.
module tb_freq_text_render;

  localparam int X0   = 16;
  localparam int Y0   = 16;
  localparam int SL   = 2;
  localparam int DOT  = 1 << SL;
  localparam int CELL = 8 * DOT;

  logic        clk;
  logic        rst;
  logic [26:0] freq_hz;
  logic        frame_start;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic [7:0]  font_ascii;
  logic [2:0]  font_row;
  logic [4:0]  font_bits;
  logic        text_on;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int unsigned shown = 0;

  freq_text_render #(.TEXT_X0(X0), .TEXT_Y0(Y0), .SCALE_LOG2(SL)) dut (
    .clk(clk), .rst(rst), .freq_hz(freq_hz), .frame_start(frame_start),
    .pix_x(pix_x), .pix_y(pix_y), .font_ascii(font_ascii), .font_row(font_row),
    .font_bits(font_bits), .text_on(text_on), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in font ROM: blank space, solid top row for 'F', arbitrary nonzero rows otherwise
  function automatic logic [4:0] tb_font(input logic [7:0] a, input logic [2:0] r);
    if (a == 8'h20) return 5'd0;
    if (a == 8'h46 && r == 3'd0) return 5'b11111;
    return 5'((int'(a) * 7 + int'(r) * 13 + 3) % 31 + 1);
  endfunction

  assign font_bits = tb_font(font_ascii, font_row);

  function automatic int unsigned clampf(input int unsigned f);
    return (f > 99_999_999) ? 99_999_999 : f;
  endfunction

  function automatic logic [7:0] exp_char(input int unsigned v, input int idx);
    logic [39:0] hdr;
    logic [23:0] tail;
    int unsigned p;
    int k;
    hdr  = "FREQ:";
    tail = " HZ";
    if (idx < 5)  return hdr[8*(4-idx) +: 8];
    if (idx > 12) return tail[8*(15-idx) +: 8];
    k = 12 - idx;
    p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
    if (k > 0 && v < p) return 8'h20;
    return 8'(32'h30 + (v / p) % 10);
  endfunction

  task automatic exp_pix(input int unsigned v, input int x, input int y,
                         output logic [7:0] a, output logic [2:0] r, output logic on);
    int rx, col;
    logic [4:0] f;
    if (x >= X0 && x < X0 + 16 * CELL && y >= Y0 && y < Y0 + 7 * DOT) begin
      rx  = x - X0;
      a   = exp_char(v, rx / CELL);
      r   = 3'((y - Y0) / DOT);
      col = (rx / DOT) % 8;
      f   = tb_font(a, r);
      on  = (col < 5) ? f[4-col] : 1'b0;
    end else begin
      a  = 8'h20;
      r  = 3'd0;
      on = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; frame_start = 1'b0; freq_hz = '0;
    pix_x = 11'(X0); pix_y = 10'(Y0);
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (font_ascii !== 8'h20) begin bad++; $display("FAIL reset_ascii: got %h want 20", font_ascii); end
    total++; if (font_row !== 3'd0) begin bad++; $display("FAIL reset_row: got %0d want 0", font_row); end
    total++; if (text_on !== 1'b0) begin bad++; $display("FAIL reset_text_on: got %b want 0", text_on); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (text_on !== 1'b0) begin bad++; $display("FAIL post_reset_text_on: got %b want 0", text_on); end
    total++; if (font_ascii !== 8'h46) begin bad++; $display("FAIL post_reset_ascii: got %h want 46", font_ascii); end
    @(negedge clk);
    total++; if (text_on !== 1'b1) begin bad++; $display("FAIL f_row0_lit: got %b want 1", text_on); end
    shown = 0;
  endtask

  task automatic test_convert(input int unsigned f);
    int busy_cyc;
    pix_x = 11'(X0 + 12 * CELL); pix_y = 10'(Y0);
    @(negedge clk);
    freq_hz = 27'(f); frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    busy_cyc = 0;
    for (int k = 1; k <= 28; k++) begin
      if (k > 1) @(negedge clk);
      if (busy === 1'b1) busy_cyc++;
      if (k == 28) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL conv_busy_end f=%0d: got %b want 0", f, busy); end
        total++; if (font_ascii !== exp_char(shown, 12)) begin
          bad++; $display("FAIL conv_early_update f=%0d: got %h want %h", f, font_ascii, exp_char(shown, 12));
        end
      end
    end
    total++; if (busy_cyc != 27) begin bad++; $display("FAIL conv_busy_len f=%0d: got %0d want 27", f, busy_cyc); end
    @(negedge clk);
    total++; if (font_ascii !== exp_char(clampf(f), 12)) begin
      bad++; $display("FAIL conv_update f=%0d: got %h want %h", f, font_ascii, exp_char(clampf(f), 12));
    end
    shown = clampf(f);
    pix_x = 11'(X0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      total++; if (font_ascii !== exp_char(shown, i) || font_row !== 3'd0) begin
        bad++; $display("FAIL string f=%0d char=%0d: got %h/%0d want %h/0", f, i, font_ascii, font_row, exp_char(shown, i));
      end
      if (i < 15) pix_x = 11'(X0 + (i + 1) * CELL);
    end
  endtask

  task automatic test_overlap;
    int unsigned f1, f2;
    int busy_cyc;
    f1 = $urandom_range(0, 99_999_999);
    f2 = $urandom_range(0, 99_999_999);
    if (f2 == f1) f2 = f1 + 1;
    pix_x = 11'(X0 + 12 * CELL); pix_y = 10'(Y0);
    @(negedge clk);
    freq_hz = 27'(f1); frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    busy_cyc = 0;
    for (int k = 1; k <= 28; k++) begin
      if (k > 1) @(negedge clk);
      if (busy === 1'b1) busy_cyc++;
      if (k == 10) begin freq_hz = 27'(f2); frame_start = 1'b1; end
      if (k == 11) frame_start = 1'b0;
    end
    total++; if (busy_cyc != 27 || busy !== 1'b0) begin
      bad++; $display("FAIL overlap_busy: got %0d cycles end=%b want 27 cycles end=0", busy_cyc, busy);
    end
    shown = f1;
    pix_x = 11'(X0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      total++; if (font_ascii !== exp_char(shown, i)) begin
        bad++; $display("FAIL overlap_string char=%0d: got %h want %h", i, font_ascii, exp_char(shown, i));
      end
      if (i < 15) pix_x = 11'(X0 + (i + 1) * CELL);
    end
  endtask

  task automatic test_reset_mid;
    int busy_cyc;
    pix_x = 11'(X0 + 12 * CELL); pix_y = 10'(Y0);
    @(negedge clk);
    freq_hz = 27'(12345); frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    busy_cyc = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_cyc++;
    end
    total++; if (busy_cyc != 0) begin bad++; $display("FAIL midrst_busy_stays: got %0d busy cycles want 0", busy_cyc); end
    total++; if (font_ascii !== 8'h30) begin bad++; $display("FAIL midrst_digit: got %h want 30", font_ascii); end
    pix_x = 11'(X0 + 11 * CELL);
    @(negedge clk);
    total++; if (font_ascii !== 8'h20) begin bad++; $display("FAIL midrst_blank: got %h want 20", font_ascii); end
    shown = 0;
  endtask

  task automatic test_sweep;
    logic [7:0] a;
    logic [2:0] r;
    logic on, prev_on;
    int lit, exp_lit;
    lit = 0; exp_lit = 0; prev_on = 1'b0;
    pix_y = 10'(Y0 + 3 * DOT);
    for (int x = 0; x <= 1024; x++) begin
      if (x < 1024) pix_x = 11'(x);
      @(negedge clk);
      if (x >= 1) begin
        if (text_on === 1'b1) lit++;
        total++; if (text_on !== prev_on) begin
          bad++; $display("FAIL sweep_text_on x=%0d: got %b want %b", x - 1, text_on, prev_on);
        end
        if (prev_on) exp_lit++;
      end
      if (x < 1024) begin
        exp_pix(shown, x, Y0 + 3 * DOT, a, r, on);
        total++; if (font_ascii !== a || font_row !== r) begin
          bad++; $display("FAIL sweep_ascii x=%0d: got %h/%0d want %h/%0d", x, font_ascii, font_row, a, r);
        end
        prev_on = on;
      end
    end
    total++; if (lit != exp_lit || exp_lit == 0) begin
      bad++; $display("FAIL sweep_lit_count: got %0d want %0d", lit, exp_lit);
    end
  endtask

  task automatic test_rand_pixels;
    logic [7:0] a;
    logic [2:0] r;
    logic on, prev_on;
    int x, y;
    prev_on = 1'b0;
    for (int n = 0; n <= 400; n++) begin
      x = $urandom_range(0, 1100);
      y = $urandom_range(0, 700);
      if (n < 400) begin pix_x = 11'(x); pix_y = 10'(y); end
      @(negedge clk);
      if (n >= 1) begin
        total++; if (text_on !== prev_on) begin
          bad++; $display("FAIL rand_text_on n=%0d: got %b want %b", n - 1, text_on, prev_on);
        end
      end
      if (n < 400) begin
        exp_pix(shown, x, y, a, r, on);
        total++; if (font_ascii !== a || font_row !== r) begin
          bad++; $display("FAIL rand_ascii (%0d,%0d): got %h/%0d want %h/%0d", x, y, font_ascii, font_row, a, r);
        end
        prev_on = on;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_convert(12345);
    test_convert(0);
    test_convert(120_000_000);
    test_overlap;
    test_reset_mid;
    test_convert(12345);
    test_sweep;
    test_convert($urandom_range(0, 134_217_727));
    test_rand_pixels;
    test_convert($urandom_range(0, 9_999));
    test_sweep;
    test_rand_pixels;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
